// File: rtl/uart_tx_arbiter.sv
// Round-robin packet scheduler sharing one UART TX FIFO between NREQ byte-stream requesters.
// Each granted packet is a header byte {id, len} followed by exactly len payload bytes.
module uart_tx_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DBIT = 8,
  parameter int unsigned LBIT = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LBIT-1:0]   req_len,
  input  logic [NREQ*DBIT-1:0]   req_data,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        gnt,
  output logic                   twr_en,
  output logic [DBIT-1:0]        twr_data,
  input  logic                   tx_full,
  output logic                   busy,
  output logic                   pkt_done
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [1:0]      id, id_nxt;
  logic [1:0]      last, last_nxt;
  logic [LBIT-1:0] len, len_nxt;
  logic [LBIT-1:0] cnt, cnt_nxt;

  logic [2*NREQ-1:0] req_rot;
  logic              found;
  int unsigned       pos;
  logic [1:0]        sel_id;
  logic [NREQ-1:0]   sel_gnt;
  logic [LBIT-1:0]   sel_len;

  logic              pay_valid;
  logic [DBIT-1:0]   pay_data;

  // Rotate the request vector so bit 0 is the requester just after `last`;
  // the first set bit of the rotated vector is the round-robin winner.
  always_comb begin
    found   = 1'b0;
    pos     = '0;
    req_rot = {req, req} >> (32'(last) + 32'd1);
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = (32'(last) + 32'd1 + k) % NREQ;
      end
    end
    sel_id  = 2'(pos);
    sel_gnt = {{(NREQ-1){1'b0}}, 1'b1} << pos;
    sel_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_gnt[i]) sel_len = req_len[i*LBIT +: LBIT];
    end
  end

  always_comb begin
    pay_valid = 1'b0;
    pay_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        pay_valid = req_valid[i];
        pay_data  = req_data[i*DBIT +: DBIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      id    <= '0;
      len   <= '0;
      cnt   <= '0;
      last  <= 2'(NREQ - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      id    <= id_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = id;
    len_nxt   = len;
    cnt_nxt   = cnt;
    last_nxt  = last;
    twr_en    = 1'b0;
    twr_data  = '0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = sel_gnt;
          id_nxt    = sel_id;
          len_nxt   = sel_len;
          last_nxt  = sel_id;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        twr_data = DBIT'({id, len});
        if (!tx_full) begin
          twr_en = 1'b1;
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          req_ready[i] = gnt[i] & ~tx_full;
        end
        if (pay_valid && !tx_full) begin
          twr_en   = 1'b1;
          twr_data = pay_data;
          cnt_nxt  = cnt + LBIT'(1);
          if (cnt_nxt == len) state_nxt = DONE;
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign pkt_done = (state == DONE);

endmodule
